// File: rtl/sha_pkg.sv
// Shared definitions for the sha224 arbiter slice: bus widths and FSM states.
package sha_pkg;

  localparam int SHA224_W = 224;
  localparam int LEN_W    = 61;
  localparam int ID_W     = 32;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

// File: rtl/sha224_arb_fifo.sv
// Owner FIFO: records the requester index of each message handed to the core,
// in completion order, so results can be routed back to their owner.
module sha224_arb_fifo
  import sha_pkg::*;
#(
  parameter int CW         = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [CW-1:0]               din,
  input  logic                        pop,
  output logic [CW-1:0]               head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rp];
  assign count   = cnt;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is allowed then.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Storage write; no reset needed, validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sha224_arbiter.sv
// Round-robin arbiter sharing one sha224 core between NCH byte-stream
// requesters. A grant lasts a whole message; results are routed back to the
// owning requester. Optional feature: SHA224_ARB_TAG_EN carries the owner in
// the top CW bits of the message id instead of an owner FIFO.
module sha224_arbiter
  import sha_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CW         = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        s_tvalid,
  output logic [NCH-1:0]        s_tready,
  input  logic [NCH-1:0]        s_tlast,
  input  logic [NCH*ID_W-1:0]   s_tid,
  input  logic [NCH*8-1:0]      s_tdata,
  input  logic                  c_tready,
  output logic                  c_tvalid,
  output logic                  c_tlast,
  output logic [ID_W-1:0]       c_tid,
  output logic [7:0]            c_tdata,
  input  logic                  c_ovalid,
  input  logic [ID_W-1:0]       c_oid,
  input  logic [LEN_W-1:0]      c_olen,
  input  logic [SHA224_W-1:0]   c_osha,
  output logic                  o_valid,
  output logic [NCH-1:0]        o_hit,
  output logic [CW-1:0]         o_ch,
  output logic [ID_W-1:0]       o_id,
  output logic [LEN_W-1:0]      o_len,
  output logic [SHA224_W-1:0]   o_sha,
  output logic                  busy,
  output logic                  err
);

  state_t          state;
  logic [CW-1:0]   gnt;
  logic [CW-1:0]   last_gnt;
  logic [CW-1:0]   rr_idx;
  logic            rr_hit;
  logic            xfer;
  logic            done;
  logic            fifo_full;
  logic [CW-1:0]   owner;
  logic            owner_ok;
  logic [ID_W-1:0] res_id;
  logic            sel_valid;
  logic            sel_last;
  logic [ID_W-1:0] sel_tid;
  logic [7:0]      sel_data;

  assign xfer = (state == XFER);
  assign done = c_tvalid & c_tready & c_tlast;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int unsigned k;
    k      = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      k = (32'(last_gnt) + i) % NCH;
      if (!rr_hit && s_tvalid[k[CW-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = k[CW-1:0];
      end
    end
  end

  // Select the granted requester's byte stream.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_tid   = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt == CW'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_tid   = s_tid[ID_W*i +: ID_W];
        sel_data  = s_tdata[8*i +: 8];
      end
    end
  end

  // Core-side outputs are gated so nothing leaks while arbitrating.
  always_comb begin
    c_tvalid = xfer & sel_valid;
    c_tlast  = xfer & sel_last;
    c_tdata  = xfer ? sel_data : '0;
`ifdef SHA224_ARB_TAG_EN
    c_tid    = xfer ? {gnt, sel_tid[ID_W-CW-1:0]} : '0;
`else
    c_tid    = xfer ? sel_tid : '0;
`endif
  end

  // Only the granted requester sees the core's ready.
  always_comb begin
    s_tready = '0;
    if (xfer) s_tready[gnt] = c_tready;
  end

  // Grant FSM: one ARB cycle, then hold the grant until tlast is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      gnt      <= '0;
      last_gnt <= CW'(NCH - 1);
    end else begin
      case (state)
        ARB: begin
          if (rr_hit && !fifo_full) begin
            gnt   <= rr_idx;
            state <= XFER;
          end
        end
        XFER: begin
          if (done) begin
            last_gnt <= gnt;
            state    <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef SHA224_ARB_TAG_EN
  assign fifo_full = 1'b0;
  assign owner     = c_oid[ID_W-1 -: CW];
  assign owner_ok  = 1'b1;
  assign res_id    = {{CW{1'b0}}, c_oid[ID_W-CW-1:0]};
  assign busy      = xfer;
  assign err       = 1'b0;
`else
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  sha224_arb_fifo #(
    .CW         (CW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done),
    .din   (gnt),
    .pop   (c_ovalid),
    .head  (owner),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign owner_ok = ~fifo_empty;
  assign res_id   = c_oid;
  assign busy     = xfer | (fifo_count != '0);

  // Sticky flag for a result that arrives with no recorded owner.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (c_ovalid && fifo_empty) err <= 1'b1;
  end
`endif

  // Register the core result and steer it to its owner one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_hit   <= '0;
      o_ch    <= '0;
      o_id    <= '0;
      o_len   <= '0;
      o_sha   <= '0;
    end else begin
      o_valid <= c_ovalid;
      o_hit   <= '0;
      if (c_ovalid) begin
        o_ch  <= '0;
        if (owner_ok) begin
          o_hit[owner] <= 1'b1;
          o_ch         <= owner;
        end
        o_id  <= res_id;
        o_len <= c_olen;
        o_sha <= c_osha;
      end
    end
  end

endmodule

// File: doc/sha224_arbiter.md
# sha224_arbiter

Round-robin scheduler that shares one `sha224` hashing core between `NCH` independent byte-stream requesters. It grants the core's input port to one requester for a whole message (first byte through `tlast`) and tracks which requester owns each in-flight message. Each core result is routed back to its owner as a one-hot strobe on a shared result bus. The block sits directly in front of the core; the core's `rstn` is driven with `~rst`.

## Interface

Parameters:
- `NCH`, 4 — number of requesters, 2..16
- `CW`, 2 — channel index width, equal to clog2(`NCH`)
- `FIFO_DEPTH`, 4 — maximum in-flight messages tracked (power of two, ≥2)

Ports:
- `clk` in 1 — single clock
- `rst` in 1 — synchronous, active-high reset
- `s_tvalid` in `NCH` — per-requester byte valid
- `s_tready` out `NCH` — per-requester ready
- `s_tlast` in `NCH` — last byte of message
- `s_tid` in `NCH*32` — per-requester message id; channel `n` is at `[32n+:32]`
- `s_tdata` in `NCH*8` — per-requester byte; channel `n` is at `[8n+:8]`
- `c_tready` in 1 — core ready
- `c_tvalid` / `c_tlast` out 1 — to core
- `c_tid` out 32 — to core
- `c_tdata` out 8 — to core
- `c_ovalid` in 1 — core result strobe
- `c_oid` in 32 — core result id
- `c_olen` in 61 — core result byte length
- `c_osha` in 224 — core digest
- `o_valid` out 1 — result strobe, one cycle
- `o_hit` out `NCH` — one-hot owner of the result
- `o_ch` out `CW` — owner index
- `o_id` out 32 — result id
- `o_len` out 61 — result byte length
- `o_sha` out 224 — result digest
- `busy` out 1 — grant active or FIFO non-empty
- `err` out 1 — sticky: result arrived with no owner recorded

## Operation

- FSM states:
  - ARB: pick the requester and register the grant.
  - XFER: pass bytes from the granted requester to the core.
- ARB:
  - Request vector is `s_tvalid`.
  - Search starts at `last_gnt+1` modulo `NCH`.
  - A grant is issued only if the owner FIFO is not full.
  - On grant: register `gnt` and enter XFER.
  - No request, or FIFO full: stay in ARB.
- XFER:
  - `c_tvalid = s_tvalid[gnt]`; `c_tlast`, `c_tid`, `c_tdata` are muxed from `gnt`.
  - `s_tready[gnt] = c_tready`; all other `s_tready` bits are 0.
  - On `c_tvalid & c_tready & c_tlast`: push `gnt` into the owner FIFO, set `last_gnt = gnt`, return to ARB.
- Outside XFER, `c_tvalid` and all `s_tready` bits are 0.
- Result path:
  - On `c_ovalid`, pop the FIFO head.
  - Next cycle: `o_valid = 1`, `o_ch = head`, `o_hit = 1<<head`, and `o_id`, `o_len`, `o_sha` carry the registered core outputs.
  - Results always return in message-completion order, so the FIFO head is always the owner.
- Push and pop in the same cycle: count unchanged, both take effect.
- `c_ovalid` with the FIFO empty:
  - Set `err` (sticky until `rst`).
  - Emit `o_valid` with `o_hit = 0` and `o_ch = 0`.
- The block does not inspect or limit message length. `tlast` alone ends the grant.

## Timing

- Reset values: all outputs 0 (`s_tready`, `c_*`, `o_*`, `busy`, `err`); FSM in ARB; `last_gnt = NCH-1`, so requester 0 has first priority; FIFO empty.
- Grant latency: a request visible in cycle N gives XFER and a possible handshake in cycle N+1.
- A requester that drops `s_tvalid` mid-message keeps the grant; no timeout.
- After each message there is one ARB cycle minimum. The core's own `tready` low period, during padding, dominates.
- Result latency: `o_valid` is exactly one cycle after `c_ovalid`. There is no backpressure; consumers must sample on `o_valid`.
- `rst` mid-message: the grant and FIFO are discarded. The core is reset together with this block, so no stale results follow.

## Configuration

- `SHA224_ARB_TAG_EN`, defined:
  - No owner FIFO.
  - `c_tid = {gnt, s_tid[gnt][31-CW:0]}`: the channel index overwrites the top `CW` id bits.
  - The owner is `c_oid[31:32-CW]`; `o_id` is `c_oid` with those bits zeroed.
  - `err` is tied to 0.
  - The FIFO-full condition is always false.
- `SHA224_ARB_TAG_EN`, undefined:
  - The owner FIFO is used and `c_tid` is passed through unmodified.

## Structure

- Shared package `sha_pkg`:
  - `SHA224_W = 224`, `LEN_W = 61`, `ID_W = 32`
  - FSM state enum {ARB, XFER}
- Sub-module `sha224_arb_fifo`:
  - Synchronous `CW`-wide FIFO, depth `FIFO_DEPTH`.
  - Signals: push, pop, head, full, empty, count.
  - Compiled out under `SHA224_ARB_TAG_EN`.
- Round-robin priority search and the input mux are kept in the top module.

## Test plan

- Single requester, channel 2 sends "abc" with tid 0x11 → one result with `o_hit = 4'b0100`, `o_ch = 2`, `o_len = 3`, `o_id = 0x11`, `o_sha = 23097d22…e36c9da7`.
- Channels 0, 1 and 3 all assert `s_tvalid` from reset with 1-byte messages → grant order 0, 1, 3, 0, …; results return with `o_ch` 0, 1, 3 in that order.
- Channel 1 holds the grant with a 100-byte message while channel 0 requests → channel 0 gets no `s_tready` until channel 1's `tlast` is accepted, then is granted after one ARB cycle.
- `FIFO_DEPTH = 2`, core result path stalled (stub core withholds `c_ovalid`) → third grant withheld until a `c_ovalid` pops the FIFO.
- Stub core pulses `c_ovalid` with the FIFO empty → `err = 1` and `o_valid = 1` with `o_hit = 0`; `err` clears only on `rst`.
- With `SHA224_ARB_TAG_EN`, channel 3 sends tid 0xFFFFFFFF → `c_tid = 0xFFFFFFFF`, `o_ch = 3`, `o_id = 0x3FFFFFFF` (`NCH = 4`).
